// File: rtl/if_fetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
// if_fetch_buffer_pkg : IF-stage constants and fetch-buffer entry type
// Revision 1.0 - initial release
// ============================================================================
package if_fetch_buffer_pkg;

  localparam int EXC_W = 19;

  // Bit positions inside the fetch exception vector
  localparam int IF_TLBRefill  = 0;
  localparam int IF_TLBInvalid = 1;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [EXC_W-1:0] except;
    logic             filled;
  } IFBuf_Entry;

endpackage
`default_nettype wire

// File: rtl/if_fetch_buffer.sv
`default_nettype none
// ============================================================================
// if_fetch_buffer : in-order IF fetch buffer with flush-time response dropping
// Optional macro IFBUF_BYPASS_EN gives zero-latency fill-to-ID at the head.
// Revision 1.0 - initial release
// ============================================================================
module if_fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int EXC_W = if_fetch_buffer_pkg::EXC_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_fire,
  input  logic [31:0]      req_pc,
  input  logic [EXC_W-1:0] req_except,
  output logic             req_allow,
  input  logic             rsp_valid,
  input  logic [31:0]      rsp_data,
  input  logic             flush,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_instr,
  output logic [EXC_W-1:0] id_except
);
  import if_fetch_buffer_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = AW + 2;

  IFBuf_Entry    mem [DEPTH];
  logic [AW-1:0] wr_ptr, fill_ptr, rd_ptr, fill_idx;
  logic [CW-1:0] count, outstanding;
  logic [DW-1:0] drop_cnt, drop_flush;
  logic          alloc, alloc_cache, req_cache, fill_en, drop_en, pop, head_ok;

  // Oldest unfilled entry at or after fill_ptr; exception entries are skipped
  always_comb begin
    fill_idx = fill_ptr;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (!mem[fill_ptr + AW'(k)].filled) fill_idx = fill_ptr + AW'(k);
    end
  end

  assign req_cache   = req_fire && (req_except == '0);
  assign alloc       = req_fire && !flush;
  assign alloc_cache = req_cache && !flush;
  assign fill_en     = rsp_valid && (drop_cnt == '0) && !flush;
  assign drop_en     = rsp_valid && (drop_cnt != '0);
  assign head_ok     = (count != '0) && mem[rd_ptr].filled;
  assign pop         = id_valid && id_ready;
  assign req_allow   = (DW'(count) + drop_cnt) < DW'(DEPTH);

  // Every response still owed by the cache must be swallowed after a flush
  assign drop_flush  = drop_cnt + DW'(outstanding) + DW'(req_cache) - DW'(rsp_valid);

  assign id_pc     = mem[rd_ptr].pc;
  assign id_except = mem[rd_ptr].except;

`ifdef IFBUF_BYPASS_EN
  logic bypass;
  assign bypass   = fill_en && (count != '0) && (fill_idx == rd_ptr);
  assign id_valid = (head_ok || bypass) && !flush;
  assign id_instr = bypass ? rsp_data : mem[rd_ptr].instr;
`else
  assign id_valid = head_ok && !flush;
  assign id_instr = mem[rd_ptr].instr;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= drop_flush;
    end else begin
      if (alloc) begin
        mem[wr_ptr].pc     <= req_pc;
        mem[wr_ptr].instr  <= '0;
        mem[wr_ptr].except <= req_except;
        mem[wr_ptr].filled <= (req_except != '0);
        wr_ptr             <= wr_ptr + AW'(1);
      end
      if (fill_en) begin
        mem[fill_idx].instr  <= rsp_data;
        mem[fill_idx].filled <= 1'b1;
        fill_ptr             <= fill_idx + AW'(1);
      end else if (pop && (fill_ptr == rd_ptr)) begin
        // Keep fill_ptr from falling behind the read side when heads are popped
        fill_ptr <= fill_ptr + AW'(1);
      end
      if (drop_en) drop_cnt <= drop_cnt - DW'(1);
      if (pop)     rd_ptr   <= rd_ptr + AW'(1);
      count       <= count + CW'(alloc) - CW'(pop);
      outstanding <= outstanding + CW'(alloc_cache) - CW'(fill_en);
    end
  end

`ifndef SYNTHESIS
  a_rsp_has_owner: assert property (@(posedge clk) disable iff (!resetn)
    rsp_valid |-> (drop_cnt != '0 || outstanding != '0));
  a_req_allowed: assert property (@(posedge clk) disable iff (!resetn)
    req_fire |-> req_allow);
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_buffer.sv
`default_nettype none
// ============================================================================
// tb_if_fetch_buffer : directed self-checking bench for if_fetch_buffer
// Revision 1.0 - initial release
// ============================================================================
module tb_if_fetch_buffer;
  import if_fetch_buffer_pkg::*;

  localparam logic [31:0] BASE = 32'hBFC0_0000;
  localparam logic [31:0] KEY  = 32'h1357_9BDF;

  logic             clk = 1'b0;
  logic             resetn;
  logic             req_fire;
  logic [31:0]      req_pc;
  logic [EXC_W-1:0] req_except;
  logic             req_allow;
  logic             rsp_valid;
  logic [31:0]      rsp_data;
  logic             flush;
  logic             id_valid;
  logic             id_ready;
  logic [31:0]      id_pc;
  logic [31:0]      id_instr;
  logic [EXC_W-1:0] id_except;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch_buffer #(.DEPTH(4), .EXC_W(EXC_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_fire   (req_fire),
    .req_pc     (req_pc),
    .req_except (req_except),
    .req_allow  (req_allow),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_pc      (id_pc),
    .id_instr   (id_instr),
    .id_except  (id_except)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chkx(input string tag, input logic [EXC_W-1:0] obs, input logic [EXC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle;
    req_fire   = 1'b0;
    req_pc     = '0;
    req_except = '0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    flush      = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [EXC_W-1:0] exc);
    req_fire   = 1'b1;
    req_pc     = pc;
    req_except = exc;
  endtask

  task automatic respond(input logic [31:0] d);
    rsp_valid = 1'b1;
    rsp_data  = d;
  endtask

  task automatic head(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                      input logic [EXC_W-1:0] exc);
    chk1 ({tag, "_valid"},  id_valid,  1'b1);
    chk32({tag, "_pc"},     id_pc,     pc);
    chk32({tag, "_instr"},  id_instr,  instr);
    chkx ({tag, "_except"}, id_except, exc);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [EXC_W-1:0] ev;
    logic [31:0]      expq[$];
    logic [31:0]      rspq[$];
    logic [31:0]      pc;
    int               issued, popped, cyc;

    ev = '0;
    ev[IF_TLBRefill] = 1'b1;

    // ---------------- reset ----------------
    resetn = 1'b0; id_ready = 1'b0; idle;
    repeat (2) @(posedge clk);
    #1;
    chk1 ("rst_id_valid",  id_valid,  1'b0);
    chk32("rst_id_pc",     id_pc,     32'h0);
    chk32("rst_id_instr",  id_instr,  32'h0);
    chkx ("rst_id_except", id_except, '0);
    chk1 ("rst_req_allow", req_allow, 1'b1);
    resetn = 1'b1;
    tick;

    // ---------------- three fetches, in-order delivery ----------------
    idle; id_ready = 1'b1; fetch(BASE, '0); tick;
    idle; fetch(BASE + 32'd4, '0); tick;
    idle; fetch(BASE + 32'd8, '0); respond(32'h2408_0001); settle;
    chk1("t1_fill_latency", id_valid, 1'b0); tick;
    idle; respond(32'h2409_0002); settle; head("t1_h0", BASE, 32'h2408_0001, '0); tick;
    idle; respond(32'h240A_0003); settle; head("t1_h1", BASE + 32'd4, 32'h2409_0002, '0); tick;
    idle; settle; head("t1_h2", BASE + 32'd8, 32'h240A_0003, '0); tick;
    idle; settle; chk1("t1_empty", id_valid, 1'b0); tick;

    // ---------------- fill to full, hold, drain ----------------
    idle; id_ready = 1'b0; fetch(BASE, '0); tick;
    idle; fetch(BASE + 32'd4,  '0); respond(32'hAAAA_0000); settle;
    chk1("t2_not_yet", id_valid, 1'b0); tick;
    idle; fetch(BASE + 32'd8,  '0); respond(32'hAAAA_0001); settle;
    head("t2_first", BASE, 32'hAAAA_0000, '0); tick;
    idle; fetch(BASE + 32'd12, '0); respond(32'hAAAA_0002); tick;
    idle; respond(32'hAAAA_0003); settle; chk1("t2_full", req_allow, 1'b0); tick;
    idle; settle; head("t2_hold", BASE, 32'hAAAA_0000, '0);
    chk1("t2_full_held", req_allow, 1'b0); tick;
    idle; id_ready = 1'b1; settle; head("t2_p0", BASE, 32'hAAAA_0000, '0);
    chk1("t2_allow_pop_cycle", req_allow, 1'b0); tick;
    idle; settle; head("t2_p1", BASE + 32'd4, 32'hAAAA_0001, '0);
    chk1("t2_allow_after_pop", req_allow, 1'b1); tick;
    idle; settle; head("t2_p2", BASE + 32'd8,  32'hAAAA_0002, '0); tick;
    idle; settle; head("t2_p3", BASE + 32'd12, 32'hAAAA_0003, '0); tick;
    idle; settle; chk1("t2_empty", id_valid, 1'b0); chk1("t2_allow_empty", req_allow, 1'b1); tick;

    // ---------------- TLB-refill entry between two cache fetches ----------------
    idle; fetch(32'hBFC0_0100, '0); tick;
    idle; fetch(32'h8000_0000, ev); tick;
    idle; fetch(32'hBFC0_0104, '0); respond(32'h3C01_0001); settle;
    chk1("t3_wait", id_valid, 1'b0); tick;
    idle; respond(32'h3C01_0002); settle; head("t3_h0", 32'hBFC0_0100, 32'h3C01_0001, '0); tick;
    idle; settle; head("t3_exc", 32'h8000_0000, 32'h0, ev); tick;
    idle; settle; head("t3_h2", 32'hBFC0_0104, 32'h3C01_0002, '0); tick;
    idle; settle; chk1("t3_empty", id_valid, 1'b0); tick;

    // ---------------- flush with responses in flight ----------------
    idle; id_ready = 1'b0; fetch(32'hBFC0_0200, '0); tick;
    idle; fetch(32'hBFC0_0204, '0); respond(32'h5555_0001); tick;
    idle; fetch(32'hBFC0_0208, '0); tick;
    idle; settle; head("t4_pre_flush", 32'hBFC0_0200, 32'h5555_0001, '0);
    flush = 1'b1; respond(32'h5555_0002); settle;
    chk1("t4_flush_masks_valid", id_valid, 1'b0); tick;
    idle; settle;
    chk1 ("t4_post_valid", id_valid, 1'b0);
    chk1 ("t4_post_allow", req_allow, 1'b1);
    chk32("t4_drop_cnt", 32'(dut.drop_cnt), 32'd1);
    fetch(32'hBFC0_0380, '0); respond(32'h5555_0003); tick;
    idle; respond(32'h4200_0018); settle;
    chk1("t4_stale_dropped", id_valid, 1'b0); tick;
    idle; id_ready = 1'b1; settle; head("t4_refetch", 32'hBFC0_0380, 32'h4200_0018, '0); tick;
    idle; settle; chk1("t4_empty", id_valid, 1'b0);
    chk32("t4_drop_done", 32'(dut.drop_cnt), 32'd0); tick;

    // ---------------- wrap-around stream with random backpressure ----------------
    issued = 0; popped = 0; cyc = 0;
    while (popped < 10 && cyc < 400) begin
      idle;
      if (rspq.size() > 0 && $urandom_range(1, 0) == 1) begin
        respond(rspq[0] ^ KEY);
        void'(rspq.pop_front());
      end
      if (issued < 10 && req_allow) begin
        pc = 32'h9000_0000 + 32'(issued * 4);
        fetch(pc, '0);
        rspq.push_back(pc);
        expq.push_back(pc);
        issued++;
      end
      id_ready = ($urandom_range(1, 0) == 1);
      settle;
      if (id_valid && id_ready) begin
        chk32("t5_pc",    id_pc,    (expq.size() > 0) ? expq[0]         : 32'hDEAD_DEAD);
        chk32("t5_instr", id_instr, (expq.size() > 0) ? (expq[0] ^ KEY) : 32'hDEAD_DEAD);
        if (expq.size() > 0) void'(expq.pop_front());
        popped++;
      end
      tick;
      cyc++;
    end
    chk32("t5_delivered", 32'(popped), 32'd10);
    chk32("t5_leftover",  32'(expq.size()), 32'd0);
    idle; id_ready = 1'b0; settle; chk1("t5_empty", id_valid, 1'b0); tick;

    // ---------------- asynchronous reset mid-operation ----------------
    idle; fetch(32'hBFC0_0500, '0); tick;
    idle; fetch(32'hBFC0_0504, '0); respond(32'h7777_0000); tick;
    idle; fetch(32'hBFC0_0508, '0); tick;
    idle; settle; head("t6_pre", 32'hBFC0_0500, 32'h7777_0000, '0);
    resetn = 1'b0; settle;
    chk1 ("t6_rst_valid", id_valid,  1'b0);
    chk1 ("t6_rst_allow", req_allow, 1'b1);
    chk32("t6_rst_pc",    id_pc,     32'h0);
    chk32("t6_rst_instr", id_instr,  32'h0);
    tick;
    resetn = 1'b1; idle; settle;
    chk32("t6_drop_cleared", 32'(dut.drop_cnt), 32'd0);
    fetch(32'hBFC0_0600, '0); tick;
    idle; respond(32'h7777_0600); tick;
    idle; id_ready = 1'b1; settle; head("t6_fresh", 32'hBFC0_0600, 32'h7777_0600, '0); tick;
    idle; settle; chk1("t6_empty", id_valid, 1'b0); tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
